// File: rtl/orb_pkg.sv
// Shared constants and FSM encoding for the orbit word arbiter.
package orb_pkg;

    localparam int ORB_N_CH    = 5;
    localparam int ORB_WORD_W  = 12;
    localparam int ORB_ADDR_W  = 11;
    localparam int ORB_CH_W    = 3;
    localparam int ORB_MEM_LAT = 2;

    localparam int CH_M16 = 0;
    localparam int CH_M8  = 1;
    localparam int CH_M4  = 2;
    localparam int CH_M2  = 3;
    localparam int CH_M1  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } orb_state_e;

endpackage

// File: rtl/orb_req_sync.sv
// Brings one former read-enable into the clk domain and flags its rising edge.
module orb_req_sync (
    input  logic clk,
    input  logic reset,
    input  logic reqAsync_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic last_q;

    // Two-flop synchroniser followed by a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            meta_q <= reqAsync_i;
            sync_q <= meta_q;
            last_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~last_q;

endmodule

// File: rtl/orb_word_arbiter.sv
// Round-robin sharing of one word store among the frame formers, with a
// fixed-latency return path into per-channel holding registers.
module orb_word_arbiter
    import orb_pkg::*;
#(
    parameter int N_CH    = ORB_N_CH,
    parameter int ADDR_W  = ORB_ADDR_W,
    parameter int WORD_W  = ORB_WORD_W,
    parameter int MEM_LAT = ORB_MEM_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            iChEn,
    input  logic [N_CH-1:0]            iReq,
    input  logic [N_CH*ADDR_W-1:0]     iAddr,
    output logic                       oMemRd,
    output logic [ORB_CH_W+ADDR_W-1:0] oMemAddr,
    input  logic [WORD_W-1:0]          iMemData,
    output logic [N_CH*WORD_W-1:0]     oWord,
    output logic [N_CH-1:0]            oWordVld,
    output logic [N_CH-1:0]            oOverrun
);

    logic [N_CH-1:0]     reqRise;
    logic [N_CH-1:0]     reqMask;
    logic [N_CH-1:0]     pend_q, pend_d;
    logic [N_CH-1:0]     ovr_q, ovr_d;
    logic [N_CH-1:0]     wordVld_q, wordVld_d;
    logic [ADDR_W-1:0]   addr_q [N_CH];
    logic [ADDR_W-1:0]   addr_d [N_CH];
    logic [WORD_W-1:0]   word_q [N_CH];
    logic [WORD_W-1:0]   word_d [N_CH];
    orb_state_e          state_q, state_d;
    logic [ORB_CH_W-1:0] ptr_q, ptr_d;
    logic [ORB_CH_W-1:0] grantIdx;
    logic                grantVld;
    logic [ORB_CH_W:0]   scanIdx;
    logic [MEM_LAT-1:0]  pipeVld_q;
    logic [ORB_CH_W-1:0] pipeTag_q [MEM_LAT];

    for (genvar g = 0; g < N_CH; g++) begin : gSync
        orb_req_sync uSync (
            .clk        (clk),
            .reset      (reset),
            .reqAsync_i (iReq[g]),
            .rise_o     (reqRise[g])
        );
        assign oWord[g*WORD_W +: WORD_W] = word_q[g];
    end

    // Pick the first enabled pending channel at or after the pointer, wrapping.
    always_comb begin
        reqMask  = pend_q & iChEn;
        grantIdx = '0;
        grantVld = 1'b0;
        scanIdx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            scanIdx = {1'b0, ptr_q} + (ORB_CH_W+1)'(k);
            if (scanIdx >= (ORB_CH_W+1)'(N_CH)) begin
                scanIdx = scanIdx - (ORB_CH_W+1)'(N_CH);
            end
            if (!grantVld && reqMask[scanIdx[ORB_CH_W-1:0]]) begin
                grantVld = 1'b1;
                grantIdx = scanIdx[ORB_CH_W-1:0];
            end
        end
        grantVld = grantVld && (state_q == ST_ISSUE) && !reset;
    end

    // Pending/address/overrun update; a new edge beats a same-cycle grant.
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        addr_d = addr_q;
        ptr_d  = ptr_q;
        if (grantVld) begin
            pend_d[grantIdx] = 1'b0;
            ptr_d = (grantIdx == ORB_CH_W'(N_CH-1)) ? '0 : grantIdx + 1'b1;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!iChEn[i]) begin
                pend_d[i] = 1'b0;
            end else if (reqRise[i]) begin
                if (pend_q[i] && !(grantVld && grantIdx == ORB_CH_W'(i))) begin
                    ovr_d[i] = 1'b1;
                end
                pend_d[i] = 1'b1;
                addr_d[i] = iAddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Arbiter FSM: wait in IDLE for work, issue one read per cycle in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = (|pend_q) ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = (|pend_d) ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Land the returning word in the tagged channel's holding register.
    always_comb begin
        word_d    = word_q;
        wordVld_d = '0;
        if (pipeVld_q[MEM_LAT-1]) begin
            word_d[pipeTag_q[MEM_LAT-1]]    = iMemData;
            wordVld_d[pipeTag_q[MEM_LAT-1]] = 1'b1;
        end
    end

    // Arbitration and request state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            addr_q  <= addr_d;
        end
    end

    // Return pipeline tracks which channel each in-flight read belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeVld_q <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                pipeTag_q[k] <= '0;
            end
        end else begin
            pipeVld_q[0] <= grantVld;
            pipeTag_q[0] <= grantIdx;
            for (int k = 1; k < MEM_LAT; k++) begin
                pipeVld_q[k] <= pipeVld_q[k-1];
                pipeTag_q[k] <= pipeTag_q[k-1];
            end
        end
    end

    // Holding registers and their update strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wordVld_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            wordVld_q <= wordVld_d;
            word_q    <= word_d;
        end
    end

    assign oMemRd   = grantVld;
    assign oMemAddr = grantVld ? {grantIdx, addr_q[grantIdx]} : '0;
    assign oWordVld = wordVld_q;
    assign oOverrun = ovr_q;

endmodule

// File: tb/tb_orb_word_arbiter.sv
// Directed bench for orb_word_arbiter with a grant/word scoreboard and a
// fixed-latency memory model.
module tb_orb_word_arbiter;
    import orb_pkg::*;

    localparam int N_CH    = ORB_N_CH;
    localparam int ADDR_W  = ORB_ADDR_W;
    localparam int WORD_W  = ORB_WORD_W;
    localparam int CH_W    = ORB_CH_W;
    localparam int MEM_LAT = 2;

    logic                   clk;
    logic                   reset;
    logic [N_CH-1:0]        iChEn;
    logic [N_CH-1:0]        iReq;
    logic [N_CH*ADDR_W-1:0] iAddr;
    logic                   oMemRd;
    logic [CH_W+ADDR_W-1:0] oMemAddr;
    logic [WORD_W-1:0]      iMemData;
    logic [N_CH*WORD_W-1:0] oWord;
    logic [N_CH-1:0]        oWordVld;
    logic [N_CH-1:0]        oOverrun;

    int checks = 0;
    int errors = 0;

    logic [CH_W+ADDR_W-1:0] grantQ [$];
    logic [CH_W+WORD_W-1:0] wordQ  [$];
    logic [CH_W+ADDR_W-1:0] rdPipe [MEM_LAT];

    orb_word_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .iChEn    (iChEn),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .oMemRd   (oMemRd),
        .oMemAddr (oMemAddr),
        .iMemData (iMemData),
        .oWord    (oWord),
        .oWordVld (oWordVld),
        .oOverrun (oOverrun)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the shared store as a function of the full address.
    function automatic logic [WORD_W-1:0] memWord(input logic [CH_W+ADDR_W-1:0] a);
        logic [11:0] lo;
        logic [11:0] hi;
        lo = a[11:0];
        hi = {9'd0, a[13:11]};
        return lo * 12'd29 + hi * 12'd331 + 12'h5A3;
    endfunction

    // Memory model: data for a read appears MEM_LAT cycles after the strobe.
    always @(posedge clk) begin
        rdPipe[0] <= oMemAddr;
        for (int k = 1; k < MEM_LAT; k++) begin
            rdPipe[k] <= rdPipe[k-1];
        end
    end
    assign iMemData = memWord(rdPipe[MEM_LAT-1]);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: every strobe and every word pulse must match the queues.
    always @(negedge clk) begin : monitor
        logic [CH_W+WORD_W-1:0] expWord;
        if (!reset) begin
            if (oMemRd) begin
                checkOutput("grantExpected", grantQ.size() != 0, 1);
                if (grantQ.size() != 0) begin
                    checkOutput("grantAddr", oMemAddr, grantQ.pop_front());
                end
            end
            if (oWordVld != '0) begin
                checkOutput("vldOneHot", $onehot(oWordVld), 1);
                for (int i = 0; i < N_CH; i++) begin
                    if (oWordVld[i]) begin
                        checkOutput("wordExpected", wordQ.size() != 0, 1);
                        if (wordQ.size() != 0) begin
                            expWord = wordQ.pop_front();
                            checkOutput("wordChan", i, expWord[CH_W+WORD_W-1:WORD_W]);
                            checkOutput("wordData", oWord[i*WORD_W +: WORD_W],
                                        expWord[WORD_W-1:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic setAddr(input int ch, input logic [ADDR_W-1:0] a);
        iAddr[ch*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic expectGrant(input int ch, input logic [ADDR_W-1:0] a, input bit withWord);
        logic [CH_W+ADDR_W-1:0] full;
        full = {CH_W'(ch), a};
        grantQ.push_back(full);
        if (withWord) wordQ.push_back({CH_W'(ch), memWord(full)});
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] reqBits, input int cycles);
        iReq = reqBits;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        iReq  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "MemRd"},   oMemRd,   0);
        checkOutput({tag, "MemAddr"}, oMemAddr, 0);
        checkOutput({tag, "Word"},    oWord,    0);
        checkOutput({tag, "WordVld"}, oWordVld, 0);
        checkOutput({tag, "Overrun"}, oOverrun, 0);
    endtask

    task automatic waitGrant(input string tag, input int budget);
        int n = 0;
        while (!oMemRd && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, oMemRd, 1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((grantQ.size() != 0 || wordQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, grantQ.size() + wordQ.size(), 0);
        repeat (6) @(negedge clk);
    endtask

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        reset = 1'b1;
        iChEn = '1;
        iReq  = '0;
        iAddr = '0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single request on ch2");
        setAddr(2, 11'h05A);
        expectGrant(2, 11'h05A, 1);
        iReq = 5'b00100;
        waitGrant("t1Grant", 10);
        checkOutput("t1MemAddr", oMemAddr, 14'h105A);
        @(negedge clk);
        checkOutput("t1RdOneCycle", oMemRd, 0);
        iReq = '0;
        drain("t1Drain", 20);
        checkOutput("t1WordHeld", oWord[2*WORD_W +: WORD_W], memWord(14'h105A));

        $display("[TB] all five channels at once");
        doReset();
        for (int i = 0; i < N_CH; i++) begin
            setAddr(i, ADDR_W'(11'h100 + 11'h11 * i));
            expectGrant(i, ADDR_W'(11'h100 + 11'h11 * i), 1);
        end
        iReq = '1;
        waitGrant("t2Grant", 10);
        repeat (4) begin
            @(negedge clk);
            checkOutput("t2BackToBack", oMemRd, 1);
        end
        @(negedge clk);
        checkOutput("t2RdEnd", oMemRd, 0);
        applyStimulus('0, 1);
        drain("t2Drain", 30);
        checkOutput("t2Overrun", oOverrun, 0);

        $display("[TB] overrun on ch1");
        doReset();
        setAddr(2, 11'h222);
        expectGrant(2, 11'h222, 1);
        iReq = 5'b00100;
        waitGrant("t3Prime", 10);
        iReq = '0;
        drain("t3PrimeDrain", 20);
        setAddr(0, 11'h300);
        setAddr(1, 11'h311);
        setAddr(3, 11'h333);
        setAddr(4, 11'h344);
        expectGrant(3, 11'h333, 1);
        expectGrant(4, 11'h344, 1);
        expectGrant(0, 11'h300, 1);
        expectGrant(1, 11'h7A1, 1);
        applyStimulus(5'b11011, 1);
        applyStimulus(5'b11001, 1);
        applyStimulus(5'b11011, 1);
        setAddr(1, 11'h7A1);
        applyStimulus(5'b11011, 4);
        iReq = '0;
        drain("t3Drain", 30);
        checkOutput("t3Overrun", oOverrun, 5'b00010);
        repeat (10) @(negedge clk);
        checkOutput("t3OverrunSticky", oOverrun, 5'b00010);

        $display("[TB] edge coincident with grant on ch3");
        doReset();
        checkOutput("t4OverrunCleared", oOverrun, 0);
        setAddr(3, 11'h4C3);
        expectGrant(3, 11'h4C3, 1);
        expectGrant(3, 11'h4C3, 1);
        applyStimulus(5'b01000, 1);
        applyStimulus(5'b00000, 1);
        applyStimulus(5'b01000, 5);
        iReq = '0;
        drain("t4Drain", 30);
        checkOutput("t4Overrun", oOverrun, 0);

        $display("[TB] reset with a read in flight");
        doReset();
        setAddr(2, 11'h055);
        expectGrant(2, 11'h055, 0);
        iReq = 5'b00100;
        waitGrant("t5Grant", 10);
        iReq = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkIdleOutputs("t5");
        drain("t5Drain", 10);
        setAddr(0, 11'h010);
        setAddr(4, 11'h014);
        expectGrant(0, 11'h010, 1);
        expectGrant(4, 11'h014, 1);
        applyStimulus(5'b10001, 6);
        iReq = '0;
        drain("t5RrDrain", 30);

        $display("[TB] ch0 disabled while toggling");
        doReset();
        iChEn = 5'b11110;
        setAddr(0, 11'h600);
        setAddr(2, 11'h626);
        expectGrant(2, 11'h626, 1);
        applyStimulus(5'b00101, 2);
        applyStimulus(5'b00100, 2);
        applyStimulus(5'b00101, 2);
        applyStimulus(5'b00001, 2);
        applyStimulus(5'b00000, 2);
        applyStimulus(5'b00001, 2);
        iReq = '0;
        drain("t6Drain", 30);
        checkOutput("t6Ch0Word", oWord[0 +: WORD_W], 0);
        checkOutput("t6Overrun", oOverrun, 0);
        iChEn = '1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
